mcu_dmi_router: RTL and testbench

MCU_DMI_ROUTER -- requirements
Module: mcu_dmi_router

---
 rtl/mcu_dmi_router.sv | 163 ++++++++++++++++
 tb/tb_mcu_dmi_router.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_dmi_router.sv
// DMI request router: decodes a DMI access onto the core or one of NUM_UNC uncore targets.
// Optional ack timeout is enabled by defining MCU_DMI_ROUTER_TIMEOUT_EN.
module mcu_dmi_router #(
  parameter int unsigned NUM_UNC     = 2,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   uncore_enable_i,
  input  logic                   dmi_en_i,
  output logic                   dmi_ready_o,
  input  logic                   dmi_wr_en_i,
  input  logic [6:0]             dmi_addr_i,
  input  logic [31:0]            dmi_wdata_i,
  output logic                   dmi_rvalid_o,
  output logic [31:0]            dmi_rdata_o,
  output logic                   dmi_err_o,
  output logic [NUM_UNC:0]       tgt_en_o,
  output logic                   tgt_wr_en_o,
  output logic [6:0]             tgt_addr_o,
  output logic [31:0]            tgt_wdata_o,
  input  logic [32*NUM_UNC+31:0] tgt_rdata_i,
  input  logic [NUM_UNC:0]       tgt_ack_i
);
  localparam int unsigned NT          = NUM_UNC + 1;
  localparam logic [31:0] TimeoutData = 32'h0BAD_0BAD;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
  state_e state_q, state_d;

  logic          wr_q, wr_d;
  logic [6:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [NT-1:0] sel_oh_q, sel_oh_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          is_core, mapped, go, accept, busy;
  logic [2:0]    unc_idx;
  logic [NT-1:0] dec_oh;
  logic          ack_sel, timeout_hit;
  logic [31:0]   sel_rdata;

  // Uncore windows are 16 registers each, starting at 0x50 (addr[6:4] == 5).
  always_comb begin
    is_core   = dmi_addr_i[6:4] <= 3'd4;
    unc_idx   = dmi_addr_i[6:4] - 3'd5;
    dec_oh    = '0;
    dec_oh[0] = is_core;
    for (int i = 1; i < NT; i++) begin
      dec_oh[i] = !is_core && (unc_idx == 3'(i - 1));
    end
    mapped = |dec_oh;
    go     = mapped && (is_core || uncore_enable_i);
    accept = (state_q == StIdle) && dmi_en_i;
    busy   = (state_q == StReq) || (state_q == StWait);
  end

  always_comb begin
    ack_sel   = |(tgt_ack_i & sel_oh_q);
    sel_rdata = '0;
    for (int i = 0; i < NT; i++) begin
      if (sel_oh_q[i]) sel_rdata = tgt_rdata_i[32*i +: 32];
    end
  end

`ifdef MCU_DMI_ROUTER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // Legal TIMEOUT_CYC is at least 2, so this is a constant 0: WAIT holds until ack or reset.
  assign timeout_hit = (TIMEOUT_CYC == 32'd0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:        if (dmi_en_i) state_d = go ? StReq : StResp;
      StReq, StWait: state_d = (ack_sel || timeout_hit) ? StResp : StWait;
      StResp:        state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    dmi_ready_o  = (state_q == StIdle);
    dmi_rvalid_o = (state_q == StResp);
    tgt_en_o     = (state_q == StReq) ? sel_oh_q : '0;
  end

  always_comb begin
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_oh_d = sel_oh_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (accept) begin
      wr_d     = dmi_wr_en_i;
      addr_d   = dmi_addr_i;
      wdata_d  = dmi_wdata_i;
      sel_oh_d = go ? dec_oh : '0;
      // Local completion: disabled uncore is silent, unmapped uncore flags an error.
      if (!go) begin
        rdata_d = '0;
        err_d   = uncore_enable_i && !mapped;
      end
    end else if (busy) begin
      if (ack_sel) begin
        if (!wr_q) rdata_d = sel_rdata;
        err_d = 1'b0;
      end else if (timeout_hit) begin
        rdata_d = TimeoutData;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_oh_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sel_oh_q <= sel_oh_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign dmi_rdata_o = rdata_q;
  assign dmi_err_o   = err_q;
  assign tgt_wr_en_o = wr_q;
  assign tgt_addr_o  = addr_q;
  assign tgt_wdata_o = wdata_q;

endmodule

// File: tb/tb_mcu_dmi_router.sv
// Directed bench for mcu_dmi_router: transaction-level expectations checked every cycle.
module tb_mcu_dmi_router;
  localparam int NU   = 2;
  localparam int NT   = NU + 1;
  localparam int TCYC = 8;
`ifdef MCU_DMI_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, uncore_enable, dmi_en, dmi_wr_en;
  logic [6:0]        dmi_addr;
  logic [31:0]       dmi_wdata;
  logic              dmi_ready, dmi_rvalid, dmi_err;
  logic [31:0]       dmi_rdata;
  logic [NT-1:0]     tgt_en, tgt_ack;
  logic              tgt_wr_en;
  logic [6:0]        tgt_addr;
  logic [31:0]       tgt_wdata;
  logic [32*NT-1:0]  tgt_rdata;

  mcu_dmi_router #(
    .NUM_UNC     (NU),
    .TIMEOUT_CYC (TCYC)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .uncore_enable_i (uncore_enable),
    .dmi_en_i        (dmi_en),
    .dmi_ready_o     (dmi_ready),
    .dmi_wr_en_i     (dmi_wr_en),
    .dmi_addr_i      (dmi_addr),
    .dmi_wdata_i     (dmi_wdata),
    .dmi_rvalid_o    (dmi_rvalid),
    .dmi_rdata_o     (dmi_rdata),
    .dmi_err_o       (dmi_err),
    .tgt_en_o        (tgt_en),
    .tgt_wr_en_o     (tgt_wr_en),
    .tgt_addr_o      (tgt_addr),
    .tgt_wdata_o     (tgt_wdata),
    .tgt_rdata_i     (tgt_rdata),
    .tgt_ack_i       (tgt_ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int obs_lat;
  logic          obs_err;
  logic [NT-1:0] obs_tgt_en;
  logic [31:0]   obs_wdata;

  // Expected state of the outputs for the current cycle.
  bit            chk_en = 1'b0;
  bit            fields_chk;
  logic          exp_ready, exp_rvalid, exp_err, exp_wr;
  logic [NT-1:0] exp_tgt_en;
  logic [31:0]   exp_rdata, exp_wdata;
  logic [6:0]    exp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(dmi_ready), 32'(exp_ready));
      chk("rvalid", 32'(dmi_rvalid), 32'(exp_rvalid));
      chk("tgt_en", 32'(tgt_en), 32'(exp_tgt_en));
      chk("rdata", dmi_rdata, exp_rdata);
      if (exp_rvalid) chk("err", 32'(dmi_err), 32'(exp_err));
      if (!exp_ready || fields_chk) begin
        chk("tgt_wr_en", 32'(tgt_wr_en), 32'(exp_wr));
        chk("tgt_addr", 32'(tgt_addr), 32'(exp_addr));
        chk("tgt_wdata", tgt_wdata, exp_wdata);
      end
    end
  end

  // Target index for an address, or -1 for an unmapped uncore address.
  function automatic int tgt_of(input logic [6:0] a);
    int ai;
    ai = int'(a);
    if (ai < 'h50) return 0;
    for (int i = 1; i <= NU; i++) begin
      if (ai >= 'h50 + 16 * (i - 1) && ai <= 'h5F + 16 * (i - 1)) return i;
    end
    return -1;
  endfunction

  function automatic logic [NT-1:0] onehot(input int t);
    logic [NT-1:0] oh;
    oh    = '0;
    oh[t] = 1'b1;
    return oh;
  endfunction

  task automatic set_exp(input logic r, input logic v, input logic [NT-1:0] te);
    exp_ready  = r;
    exp_rvalid = v;
    exp_tgt_en = te;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (dmi_rvalid && obs_lat < 0) begin
      obs_lat = cyc;
      obs_err = dmi_err;
    end
  endtask

  // One DMI access; starts and ends in an idle cycle. ack_dly < 0 means the target never acks.
  task automatic txn(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                     input logic uen, input int ack_dly, input logic [31:0] ack_data,
                     input bit hold);
    int t, k, other;
    bit go, timed_out;
    t         = tgt_of(addr);
    go        = (t == 0) || (t > 0 && uen);
    timed_out = 1'b0;
    dmi_en = 1'b1; dmi_wr_en = wr; dmi_addr = addr; dmi_wdata = wd; uncore_enable = uen;
    obs_lat = -1; obs_err = 1'b0;
    cyc = 0;
    step();
    if (!hold) dmi_en = 1'b0;
    uncore_enable = ~uen;
    exp_wr = wr; exp_addr = addr; exp_wdata = wd; fields_chk = 1'b0;
    obs_tgt_en = tgt_en;
    obs_wdata  = tgt_wdata;
    if (!go) begin
      exp_rdata = '0;
      exp_err   = (t < 0) && uen;
      set_exp(1'b0, 1'b1, '0);
    end else begin
      k = 0;
      other = (t + 1) % NT;
      forever begin
        set_exp(1'b0, 1'b0, (k == 0) ? onehot(t) : '0);
        if (k == ack_dly) begin
          tgt_ack[t] = 1'b1;
          tgt_rdata[32*t +: 32] = ack_data;
          step();
          tgt_ack = '0;
          if (!wr) exp_rdata = ack_data;
          exp_err = 1'b0;
          break;
        end
        if (TO_EN && k == TCYC - 1) begin
          step();
          exp_rdata = 32'h0BAD_0BAD;
          exp_err   = 1'b1;
          timed_out = 1'b1;
          break;
        end
        if (k == 0) tgt_ack[other] = 1'b1;
        step();
        tgt_ack = '0;
        k++;
        if (k > 64) begin
          n_vec++; n_err++;
          $display("FAIL wait_bound: got no completion after %0d cycles, want one", k);
          break;
        end
      end
      set_exp(1'b0, 1'b1, '0);
    end
    step();
    set_exp(1'b1, 1'b0, '0);
    if (timed_out) begin
      tgt_ack[t] = 1'b1;
      step();
      tgt_ack = '0;
      set_exp(1'b1, 1'b0, '0);
    end
  endtask

  initial begin
    rst = 1'b1; uncore_enable = 1'b0; dmi_en = 1'b0; dmi_wr_en = 1'b0;
    dmi_addr = '0; dmi_wdata = '0; tgt_ack = '0;
    tgt_rdata = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    repeat (2) @(posedge clk);
    #1;
    exp_rdata = '0; exp_err = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
    fields_chk = 1'b1;
    set_exp(1'b1, 1'b0, '0);
    chk_en = 1'b1;
    chk("reset_ready", 32'(dmi_ready), 32'd1);
    chk("reset_rdata", dmi_rdata, 32'd0);
    chk("reset_err", 32'(dmi_err), 32'd0);
    rst = 1'b0;
    step();

    // Core read, ack one cycle after tgt_en.
    txn(1'b0, 7'h04, 32'h0, 1'b1, 1, 32'h1234_5678, 1'b0);
    chk("core_rd_lat", obs_lat, 3);
    chk("core_rd_tgt_en", 32'(obs_tgt_en), 32'b001);
    chk("core_rd_rdata", dmi_rdata, 32'h1234_5678);
    chk("core_rd_err", 32'(obs_err), 32'd0);

    // Uncore write to target 2, ack with tgt_en.
    txn(1'b1, 7'h62, 32'hA5A5_A5A5, 1'b1, 0, 32'hFFFF_0000, 1'b0);
    chk("unc_wr_lat", obs_lat, 2);
    chk("unc_wr_tgt_en", 32'(obs_tgt_en), 32'b100);
    chk("unc_wr_wdata", obs_wdata, 32'hA5A5_A5A5);
    chk("unc_wr_rdata", dmi_rdata, 32'h1234_5678);

    // Uncore disabled, then unmapped uncore.
    txn(1'b0, 7'h55, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    chk("unc_off_lat", obs_lat, 1);
    chk("unc_off_tgt_en", 32'(obs_tgt_en), 32'd0);
    chk("unc_off_rdata", dmi_rdata, 32'd0);
    chk("unc_off_err", 32'(obs_err), 32'd0);
    txn(1'b0, 7'h75, 32'h0, 1'b1, 0, 32'h0, 1'b0);
    chk("unmapped_rdata", dmi_rdata, 32'd0);
    chk("unmapped_err", 32'(obs_err), 32'd1);

    txn(1'b0, 7'h5A, 32'h0, 1'b1, 3, 32'hCAFE_0001, 1'b0);
    txn(1'b1, 7'h4F, 32'h0101_0101, 1'b0, 2, 32'h7777_7777, 1'b0);
    txn(1'b0, 7'h6F, 32'h0, 1'b1, 12, 32'h0000_BEEF, 1'b0);
    txn(1'b0, 7'h50, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    txn(1'b0, 7'h7F, 32'h0, 1'b0, 0, 32'h0, 1'b0);

    // dmi_en held across a transaction: re-accepted only after RESP.
    txn(1'b0, 7'h10, 32'h0, 1'b1, 0, 32'h0F0F_0F0F, 1'b1);
    txn(1'b0, 7'h10, 32'h0, 1'b1, 1, 32'h3C3C_3C3C, 1'b0);
    chk("hold_rdata", dmi_rdata, 32'h3C3C_3C3C);

    // Reset while waiting on the core, then a stale ack.
    dmi_en = 1'b1; dmi_wr_en = 1'b0; dmi_addr = 7'h04; dmi_wdata = 32'h1111_1111;
    step();
    dmi_en = 1'b0;
    exp_wr = 1'b0; exp_addr = 7'h04; exp_wdata = 32'h1111_1111; fields_chk = 1'b0;
    set_exp(1'b0, 1'b0, 3'b001);
    step();
    set_exp(1'b0, 1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rdata = '0; exp_err = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
    fields_chk = 1'b1;
    set_exp(1'b1, 1'b0, '0);
    tgt_ack[0] = 1'b1;
    tgt_rdata[31:0] = 32'h5555_AAAA;
    step();
    tgt_ack = '0;
    set_exp(1'b1, 1'b0, '0);
    chk("rst_rvalid", 32'(dmi_rvalid), 32'd0);
    chk("rst_ready", 32'(dmi_ready), 32'd1);
    chk("rst_rdata", dmi_rdata, 32'd0);
    chk("rst_addr", 32'(tgt_addr), 32'd0);
    step();

    txn(1'b0, 7'h20, 32'h0, 1'b1, 0, 32'h7777_0000, 1'b0);
    chk("post_rst_rdata", dmi_rdata, 32'h7777_0000);

`ifdef MCU_DMI_ROUTER_TIMEOUT_EN
    txn(1'b0, 7'h55, 32'h0, 1'b1, -1, 32'h0, 1'b0);
    chk("timeout_lat", obs_lat, TCYC + 1);
    chk("timeout_rdata", dmi_rdata, 32'h0BAD_0BAD);
    chk("timeout_err", 32'(obs_err), 32'd1);
`endif

    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
